fadd_arbiter: RTL and testbench
===============================

Name: fadd_arbiter

Overview:
Shares one pipelined single-precision `fadd` unit among N_REQ requesters. Each requester has its own request/response handshake. Per cycle the block selects at most one requester round-robin and drives its operands into `fadd`. A requester-tag pipeline matched to the `fadd` latency routes each `fadd` result back to the requester that issued it. The block sits between the FPU datapath clients and the `fadd` instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
LAT, 3, `fadd` latency: `fadd_y` is valid LAT cycles after `fadd_x1`/`fadd_x2` are presented
TAG_W, $clog2(N_REQ), width of the requester index

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester operation request
req_ready  out  N_REQ  per-requester accept; combinational
req_x1  in  N_REQ x 32  operand x1 per requester
req_x2  in  N_REQ x 32  operand x2 per requester
rsp_valid  out  N_REQ  per-requester result available
rsp_ready  in  N_REQ  per-requester result consumed
rsp_y  out  N_REQ x 32  per-requester result register
fadd_x1  out  32  registered operand x1 to `fadd`
fadd_x2  out  32  registered operand x2 to `fadd`
fadd_y  in  32  result from `fadd`
busy  out  N_REQ  requester i has an operation in flight or an unconsumed result

Behaviour:
- Clock is `clk`; reset is synchronous active-high. All of the following are 0 after reset: `fadd_x1`, `fadd_x2`, `rsp_valid`, `rsp_y`, `busy`, the tag pipeline, and `rr_ptr`.
- Eligibility: requester i is eligible when `req_valid[i]` is 1 and `busy[i]` is 0.
- Grant: combinational. Pick the first eligible index, searching from `rr_ptr` upward with wrap-around. `req_ready[i]` is 1 only for the granted index; all other bits are 0.
- `req_ready` depends only on `req_valid` and registered state, never on `rsp_ready`.
- Accept happens at the clock edge where `req_valid[g] && req_ready[g]` for granted index g. At that edge:
  - `fadd_x1`/`fadd_x2` <= `req_x1[g]`/`req_x2[g]`;
  - tag stage 0 <= {valid=1, tag=g};
  - `busy[g]` <= 1;
  - `rr_ptr` <= (g+1) mod N_REQ.
- No accept at an edge:
  - `fadd_x1`/`fadd_x2` <= 0 (0+0 keeps `fadd` quiescent);
  - stage 0 valid <= 0;
  - `rr_ptr` unchanged.
- Tag pipeline: LAT+1 stages, shifting every cycle, with no stall. `fadd` has no enable, so the pipeline must never stall.
- Capture: when the final tag stage is valid with tag t, then at that edge `rsp_y[t]` <= `fadd_y` and `rsp_valid[t]` <= 1.
- Latency: `rsp_valid` rises exactly LAT+1 cycles after the accept edge. Example, LAT=3: accept at edge 0, `rsp_valid` is high from cycle 4.
- One outstanding operation per requester. This guarantees the result slot is free at capture, so no overflow case exists.
- Response handshake: `rsp_valid[i]` holds, and `rsp_y[i]` stays stable, until `rsp_ready[i]` is sampled high. At that edge, `rsp_valid[i]` <= 0 and `busy[i]` <= 0.
- Same-requester simultaneous events: if requester i completes its response handshake and asserts `req_valid` in the same cycle, it is not ready that cycle, because `busy` is registered. Its earliest new accept is the next cycle.
- Back-to-back issue: different requesters may be accepted on consecutive cycles, giving full `fadd` throughput of 1 op/cycle.
- Captures for different requesters land on different cycles, so no capture conflict is possible.
- `rst` mid-operation: all in-flight tags, results and `busy` bits are discarded. `fadd` outputs emerging after reset are ignored because the tag valids are 0.
- `rsp_y` is not cleared on response consumption; only `rsp_valid` qualifies it.

Decomposition:
- Package `fpu_pkg`:
  - `float_t` (logic [31:0]);
  - `FADD_LAT` constant (default source for LAT);
  - `tag_entry_t` struct {valid, tag}.
- Sub-module `rr_arbiter`:
  - parameter N;
  - inputs: `eligible[N]`, `ptr`;
  - outputs: `grant_onehot`, `grant_idx`, `any`.
- Tag shift register, operand registers and result slots stay in the top module.

Test Plan:
- Single op, LAT=3: requester 0 sends x1=0x40400000, x2=0x40000000. Expect `rsp_valid[0]` 4 cycles after accept, `rsp_y[0]`=0x40A00000, `busy[0]`=1 until `rsp_ready[0]`.
- Round-robin: all 4 requesters valid in the same cycle with 3+(-3), 0+0, 1+1.1 (0x3f800000+0x3f8ccccd), 2.5+2. Expect grants in order 0,1,2,3 on consecutive cycles. Expect results 0x00000000, 0x00000000, 0x40066666, 0x40900000, arriving on consecutive cycles at their owners.
- Fairness: requesters 1 and 2 continuously valid, consuming responses immediately. Expect alternating grants 1,2,1,2 and no starvation.
- Backpressure: requester 2 holds `rsp_ready`=0 for 10 cycles. Expect `rsp_y[2]` stable, `req_ready[2]`=0 throughout, while other requesters keep issuing.
- Reset mid-flight: assert `rst` 1 cycle after two accepts. Expect all `rsp_valid`=0, `busy`=0, and no stale capture over the following LAT+2 cycles.
- Same-cycle consume and re-request on requester 3: expect the accept exactly 1 cycle after `rsp_ready`, never in the same cycle.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU types: float word, fadd latency and the requester tag that rides
// alongside each operation through the fadd pipeline.
package fpu_pkg;
    typedef logic [31:0] float_t;

    localparam int FADD_LAT  = 3;
    localparam int TAG_MAX_W = 3;   // enough for up to 8 requesters

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
    } tag_entry_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or above ptr,
// wrapping around.
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant_onehot,
    output logic [W-1:0] grant_idx,
    output logic         any
);
    always_comb begin
        int idx;
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        idx          = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && eligible[idx]) begin
                any               = 1'b1;
                grant_onehot[idx] = 1'b1;
                grant_idx         = W'(idx);
            end
        end
    end
endmodule

// File: rtl/fadd_arbiter.sv
// Shares one pipelined fadd among N_REQ requesters; a tag pipeline matched to
// the fadd latency steers each result back into its owner's response slot.
module fadd_arbiter
    import fpu_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int LAT   = FADD_LAT,
    parameter int TAG_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic   [N_REQ-1:0]     req_valid,
    output logic   [N_REQ-1:0]     req_ready,
    input  float_t [N_REQ-1:0]     req_x1,
    input  float_t [N_REQ-1:0]     req_x2,
    output logic   [N_REQ-1:0]     rsp_valid,
    input  logic   [N_REQ-1:0]     rsp_ready,
    output float_t [N_REQ-1:0]     rsp_y,
    output float_t                 fadd_x1,
    output float_t                 fadd_x2,
    input  float_t                 fadd_y,
    output logic   [N_REQ-1:0]     busy
);
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant_onehot;
    logic [TAG_W-1:0] grant_idx;
    logic [TAG_W-1:0] rr_ptr;
    logic             accept;
    logic [N_REQ-1:0] cap_hit;
    tag_entry_t       tag_pipe [LAT+1];

    // busy blocks a requester until its result is consumed, so the slot is
    // always free when the result lands
    assign eligible = req_valid & ~busy;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .eligible     (eligible),
        .ptr          (rr_ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (accept)
    );

    assign req_ready = grant_onehot;

    always_comb begin
        cap_hit = '0;
        for (int i = 0; i < N_REQ; i++)
            cap_hit[i] = tag_pipe[LAT].valid && (tag_pipe[LAT].tag == TAG_MAX_W'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fadd_x1   <= '0;
            fadd_x2   <= '0;
            rsp_valid <= '0;
            rsp_y     <= '0;
            busy      <= '0;
            rr_ptr    <= '0;
            for (int k = 0; k <= LAT; k++)
                tag_pipe[k] <= '0;
        end else begin
            // fadd has no enable, so the tag pipe shifts every cycle
            tag_pipe[0].valid <= accept;
            tag_pipe[0].tag   <= accept ? TAG_MAX_W'(grant_idx) : '0;
            for (int k = 1; k <= LAT; k++)
                tag_pipe[k] <= tag_pipe[k-1];

            if (accept) begin
                fadd_x1 <= req_x1[grant_idx];
                fadd_x2 <= req_x2[grant_idx];
                rr_ptr  <= (grant_idx == TAG_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
            end else begin
                fadd_x1 <= '0;
                fadd_x2 <= '0;
            end

            for (int i = 0; i < N_REQ; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                    busy[i]      <= 1'b0;
                end
                if (accept && grant_onehot[i])
                    busy[i] <= 1'b1;
                if (cap_hit[i]) begin
                    rsp_valid[i] <= 1'b1;
                    rsp_y[i]     <= fadd_y;
                end
            end
        end
    end
endmodule

// File: tb/tb_fadd_arbiter.sv
// Bench for fadd_arbiter: behavioural fadd stub, transaction-level reference
// model, directed scenarios then randomized traffic.
module tb_fadd_arbiter;
    import fpu_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic   [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready, busy;
    float_t [N-1:0] req_x1, req_x2, rsp_y;
    float_t         fadd_x1, fadd_x2, fadd_y;

    always #5 clk = ~clk;

    fadd_arbiter #(.N_REQ(N), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x1(req_x1), .req_x2(req_x2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .fadd_x1(fadd_x1), .fadd_x2(fadd_x2), .fadd_y(fadd_y),
        .busy(busy)
    );

    // Known float sums for the directed vectors; any other pair gets an
    // arbitrary but deterministic value so routing is still observable.
    function automatic float_t fadd_fn(float_t a, float_t b);
        if (a == 32'h40400000 && b == 32'h40000000) return 32'h40A00000;
        if (a == 32'h40400000 && b == 32'hC0400000) return 32'h00000000;
        if (a == 32'h3F800000 && b == 32'h3F8CCCCD) return 32'h40066666;
        if (a == 32'h40200000 && b == 32'h40000000) return 32'h40900000;
        if (a == 32'h0 && b == 32'h0)               return 32'h0;
        return a + b + 32'h1234_5678;
    endfunction

    float_t fpipe [LAT];
    always @(posedge clk) begin
        fpipe[0] <= fadd_fn(fadd_x1, fadd_x2);
        for (int k = 1; k < LAT; k++) fpipe[k] <= fpipe[k-1];
    end
    assign fadd_y = fpipe[LAT-1];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model: per-requester status plus a list of in-flight ops
    typedef struct { int r; float_t y; int due; } op_t;
    op_t     inflight [$];
    logic [N-1:0] m_busy, m_rv;
    float_t  m_y [N];
    int      m_ptr;
    float_t  m_fx1, m_fx2;
    int      cyc = 0;
    logic [N-1:0] seen_ready;

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int idx = (m_ptr + k) % N;
            if (req_valid[idx] && !m_busy[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int oh_idx(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // One clock: check grant with settled inputs, advance the model across
    // the edge, then check registered outputs on the falling edge.
    task automatic step();
        int g;
        logic [N-1:0] exp_rdy;
        #1;
        g = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        seen_ready = req_ready;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_busy = '0; m_rv = '0; m_ptr = 0; m_fx1 = '0; m_fx2 = '0;
            for (int i = 0; i < N; i++) m_y[i] = '0;
            inflight.delete();
        end else begin
            for (int i = 0; i < N; i++)
                if (m_rv[i] && rsp_ready[i]) begin m_rv[i] = 1'b0; m_busy[i] = 1'b0; end
            for (int k = inflight.size() - 1; k >= 0; k--)
                if (inflight[k].due == cyc) begin
                    m_rv[inflight[k].r] = 1'b1;
                    m_y[inflight[k].r]  = inflight[k].y;
                    inflight.delete(k);
                end
            if (g >= 0) begin
                m_busy[g] = 1'b1;
                inflight.push_back('{g, fadd_fn(req_x1[g], req_x2[g]), cyc + LAT + 1});
                m_ptr = (g + 1) % N;
                m_fx1 = req_x1[g];
                m_fx2 = req_x2[g];
            end else begin
                m_fx1 = '0;
                m_fx2 = '0;
            end
        end
        @(negedge clk);
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("fadd_x1", fadd_x1, m_fx1);
        chk("fadd_x2", fadd_x2, m_fx2);
        for (int i = 0; i < N; i++)
            if (m_rv[i]) chk("rsp_y", rsp_y[i], m_y[i]);
    endtask

    task automatic reset_dut();
        rst = 1'b1; req_valid = '0; rsp_ready = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic drain();
        req_valid = '0; rsp_ready = '1;
        repeat (LAT + 4) step();
        rsp_ready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, g, others;
        int order [N];
        int rise [N];
        int grants [$];
        float_t held;

        rst = 1'b1; req_valid = '0; rsp_ready = '0; req_x1 = '0; req_x2 = '0;
        @(negedge clk);
        reset_dut();
        for (int i = 0; i < N; i++) chk("rst_rsp_y", rsp_y[i], 32'h0);

        // single op, latency and busy hold
        req_valid = 4'b0001; req_x1[0] = 32'h40400000; req_x2[0] = 32'h40000000;
        step();
        chk("t1_grant", 32'(seen_ready), 32'h1);
        req_valid = '0;
        n = 0;
        while (!rsp_valid[0] && n < 20) begin step(); n++; end
        chk("t1_latency", n, LAT + 1);
        chk("t1_y", rsp_y[0], 32'h40A00000);
        step(); step();
        chk("t1_busy_hold", 32'(busy[0]), 32'h1);
        rsp_ready[0] = 1'b1; step(); rsp_ready = '0;
        chk("t1_busy_clr", 32'(busy[0]), 32'h0);

        // round robin from a fresh pointer
        reset_dut();
        req_x1[0] = 32'h40400000; req_x2[0] = 32'hC0400000;
        req_x1[1] = 32'h00000000; req_x2[1] = 32'h00000000;
        req_x1[2] = 32'h3F800000; req_x2[2] = 32'h3F8CCCCD;
        req_x1[3] = 32'h40200000; req_x2[3] = 32'h40000000;
        req_valid = 4'hF;
        for (int k = 0; k < N; k++) begin
            step();
            order[k] = oh_idx(seen_ready);
            req_valid = req_valid & ~seen_ready;
        end
        for (int k = 0; k < N; k++) chk("t2_order", order[k], k);
        for (int i = 0; i < N; i++) rise[i] = -1;
        n = 0;
        while (rise[N-1] < 0 && n < 12) begin
            step(); n++;
            for (int i = 0; i < N; i++) if (rsp_valid[i] && rise[i] < 0) rise[i] = cyc;
        end
        for (int i = 1; i < N; i++) chk("t2_consecutive", rise[i] - rise[0], i);
        chk("t2_y0", rsp_y[0], 32'h00000000);
        chk("t2_y1", rsp_y[1], 32'h00000000);
        chk("t2_y2", rsp_y[2], 32'h40066666);
        chk("t2_y3", rsp_y[3], 32'h40900000);
        drain();

        // fairness between two always-valid requesters
        req_valid = 4'b0110; rsp_ready = 4'b0110;
        repeat (30) begin
            req_x1 = {$urandom, $urandom, $urandom, $urandom};
            req_x2 = {$urandom, $urandom, $urandom, $urandom};
            step();
            g = oh_idx(seen_ready);
            if (g >= 0) grants.push_back(g);
        end
        chk("t3_count", 32'(grants.size() >= 8), 32'h1);
        for (int k = 1; k < grants.size(); k++)
            chk("t3_alternate", grants[k], (grants[k-1] == 1) ? 2 : 1);
        drain();

        // backpressure on requester 2 while the others keep issuing
        req_valid = 4'b0100; req_x1[2] = $urandom; req_x2[2] = $urandom;
        step();
        req_valid = 4'hF; rsp_ready = 4'b1011;
        n = 0;
        while (!rsp_valid[2] && n < 20) begin step(); n++; end
        chk("t4_rsp_seen", 32'(rsp_valid[2]), 32'h1);
        held = rsp_y[2];
        others = 0;
        repeat (10) begin
            req_x1 = {$urandom, req_x1[2], $urandom, $urandom};
            step();
            chk("t4_y_stable", rsp_y[2], held);
            chk("t4_ready2_low", 32'(seen_ready[2]), 32'h0);
            if (seen_ready & 4'b1011) others++;
        end
        chk("t4_others_issue", 32'(others > 3), 32'h1);
        rsp_ready[2] = 1'b1; req_valid = '0; step();
        drain();

        // reset with two ops in flight
        reset_dut();
        req_valid = 4'b0011; req_x1 = {$urandom, $urandom, $urandom, $urandom};
        step(); chk("t5_g0", 32'(seen_ready), 32'h1);
        step(); chk("t5_g1", 32'(seen_ready), 32'h2);
        req_valid = '0; step();
        rst = 1'b1; step(); rst = 1'b0;
        repeat (LAT + 2) begin
            step();
            chk("t5_no_valid", 32'(rsp_valid), 32'h0);
            chk("t5_no_busy", 32'(busy), 32'h0);
        end

        // consume and re-request in the same cycle on requester 3
        req_valid = 4'b1000; req_x1[3] = $urandom; req_x2[3] = $urandom;
        step(); req_valid = '0;
        n = 0;
        while (!rsp_valid[3] && n < 20) begin step(); n++; end
        rsp_ready[3] = 1'b1; req_valid[3] = 1'b1;
        step();
        chk("t6_same_cycle", 32'(seen_ready[3]), 32'h0);
        rsp_ready = '0;
        step();
        chk("t6_next_cycle", 32'(seen_ready[3]), 32'h1);
        drain();

        // randomized traffic with occasional reset
        repeat (400) begin
            rst       = ($urandom_range(63) == 0);
            req_valid = N'($urandom);
            rsp_ready = N'($urandom);
            req_x1    = {$urandom, $urandom, $urandom, $urandom};
            req_x2    = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        rst = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
